// File: rtl/axi_write_router_pkg.sv
// Shared AXI definitions for the crossbar write/read routers.
// Provides bus-width macros, slave-select one-hot encoding, router FSM states,
// region base/mask defaults and the master ID tag.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package axi_write_router_pkg;

  // One-hot slave select.
  typedef enum logic [2:0] {
    SEL_S0 = 3'b001,
    SEL_S1 = 3'b010,
    SEL_DS = 3'b100
  } slv_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW_SEND,
    ST_W_FWD,
    ST_B_WAIT
  } wr_state_e;

  localparam logic [`AXI_ADDR_BITS-1:0] S0_BASE_DEF     = 32'h0000_0000;
  localparam logic [`AXI_ADDR_BITS-1:0] S1_BASE_DEF     = 32'h0001_0000;
  localparam logic [`AXI_ADDR_BITS-1:0] REGION_MASK_DEF = 32'hFFFF_0000;

  // Upper ID bits identifying master M1 on the slave side.
  localparam int unsigned ID_TAG_BITS = `AXI_IDS_BITS - `AXI_ID_BITS;
  localparam logic [ID_TAG_BITS-1:0] M1_TAG_DEF = 4'd1;

endpackage

// File: rtl/axi_write_router_addr_decoder.sv
// Address decoder: maps an AXI address to a one-hot slave select (S0 > S1 > DS).
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: addr in (`AXI_ADDR_BITS), sel out (3, one-hot {DS,S1,S0}).
module axi_addr_decoder
  import axi_write_router_pkg::*;
#(
  parameter logic [`AXI_ADDR_BITS-1:0] S0_BASE     = S0_BASE_DEF,
  parameter logic [`AXI_ADDR_BITS-1:0] S1_BASE     = S1_BASE_DEF,
  parameter logic [`AXI_ADDR_BITS-1:0] REGION_MASK = REGION_MASK_DEF
) (
  input  logic [`AXI_ADDR_BITS-1:0] addr,
  output logic [2:0]                sel
);

  logic hit_s0;
  logic hit_s1;

  assign hit_s0 = ((addr & REGION_MASK) == (S0_BASE & REGION_MASK));
  assign hit_s1 = ((addr & REGION_MASK) == (S1_BASE & REGION_MASK));

  always_comb begin
    sel = SEL_DS;
    if (hit_s0)      sel = SEL_S0;
    else if (hit_s1) sel = SEL_S1;
  end

endmodule

// File: rtl/axi_write_router.sv
// AXI write-request router: M1 AW/W steered to S0, S1 or default slave DS, one write outstanding.
// Latency: AW reaches the slave 1 cycle after the M1 handshake; W beats pass through combinationally.
// Backpressure: M1_AWReady only in IDLE; M1_WReady follows the target WReady in W_FWD, else 0.
// Ports: clk, rst (async active-low); M1 AW/W channels in, M1_BValid/BReady tap in;
//        per-slave (S0, S1, DS) AW/W channels out with their AWReady/WReady in; wr_busy out.
// Option WRITE_BEAT_CHECK_EN: WLast regenerated from the beat counter, adds sticky wlast_err out.
module axi_write_router
  import axi_write_router_pkg::*;
#(
  parameter logic [`AXI_ADDR_BITS-1:0] S0_BASE     = S0_BASE_DEF,
  parameter logic [`AXI_ADDR_BITS-1:0] S1_BASE     = S1_BASE_DEF,
  parameter logic [`AXI_ADDR_BITS-1:0] REGION_MASK = REGION_MASK_DEF,
  parameter logic [ID_TAG_BITS-1:0]    M1_TAG      = M1_TAG_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`AXI_ID_BITS-1:0]    M1_AWID,
  input  logic [`AXI_ADDR_BITS-1:0]  M1_AWADDR,
  input  logic [`AXI_LEN_BITS-1:0]   M1_AWLEN,
  input  logic [`AXI_SIZE_BITS-1:0]  M1_AWSIZE,
  input  logic [1:0]                 M1_AWBURST,
  input  logic                       M1_AWValid,
  output logic                       M1_AWReady,
  input  logic [`AXI_DATA_BITS-1:0]  M1_WData,
  input  logic [`AXI_STRB_BITS-1:0]  M1_WStrb,
  input  logic                       M1_WLast,
  input  logic                       M1_WValid,
  output logic                       M1_WReady,
  input  logic                       M1_BValid,
  input  logic                       M1_BReady,
  output logic [`AXI_IDS_BITS-1:0]   S0_AWID,
  output logic [`AXI_ADDR_BITS-1:0]  S0_AWADDR,
  output logic [`AXI_LEN_BITS-1:0]   S0_AWLEN,
  output logic [`AXI_SIZE_BITS-1:0]  S0_AWSIZE,
  output logic [1:0]                 S0_AWBURST,
  output logic                       S0_AWValid,
  input  logic                       S0_AWReady,
  output logic [`AXI_DATA_BITS-1:0]  S0_WData,
  output logic [`AXI_STRB_BITS-1:0]  S0_WStrb,
  output logic                       S0_WLast,
  output logic                       S0_WValid,
  input  logic                       S0_WReady,
  output logic [`AXI_IDS_BITS-1:0]   S1_AWID,
  output logic [`AXI_ADDR_BITS-1:0]  S1_AWADDR,
  output logic [`AXI_LEN_BITS-1:0]   S1_AWLEN,
  output logic [`AXI_SIZE_BITS-1:0]  S1_AWSIZE,
  output logic [1:0]                 S1_AWBURST,
  output logic                       S1_AWValid,
  input  logic                       S1_AWReady,
  output logic [`AXI_DATA_BITS-1:0]  S1_WData,
  output logic [`AXI_STRB_BITS-1:0]  S1_WStrb,
  output logic                       S1_WLast,
  output logic                       S1_WValid,
  input  logic                       S1_WReady,
  output logic [`AXI_IDS_BITS-1:0]   DS_AWID,
  output logic [`AXI_ADDR_BITS-1:0]  DS_AWADDR,
  output logic [`AXI_LEN_BITS-1:0]   DS_AWLEN,
  output logic [`AXI_SIZE_BITS-1:0]  DS_AWSIZE,
  output logic [1:0]                 DS_AWBURST,
  output logic                       DS_AWValid,
  input  logic                       DS_AWReady,
  output logic [`AXI_DATA_BITS-1:0]  DS_WData,
  output logic [`AXI_STRB_BITS-1:0]  DS_WStrb,
  output logic                       DS_WLast,
  output logic                       DS_WValid,
  input  logic                       DS_WReady,
  output logic                       wr_busy
`ifdef WRITE_BEAT_CHECK_EN
  ,
  output logic                       wlast_err
`endif
);

  wr_state_e                  state_q, state_d;
  logic [`AXI_ADDR_BITS-1:0]  awaddr_q;
  logic [`AXI_LEN_BITS-1:0]   awlen_q;
  logic [`AXI_SIZE_BITS-1:0]  awsize_q;
  logic [1:0]                 awburst_q;
  logic [`AXI_IDS_BITS-1:0]   awid_q;
  logic [2:0]                 sel_q, sel_dec;
  // One extra bit so a 16-beat burst counts to 16 without wrapping.
  logic [`AXI_LEN_BITS:0]     cnt_q;
  logic                       w_hs, b_hs, tgt_awready, tgt_wready;
  logic                       cnt_last, beat_last;
  logic [2:0]                 aw_sel, w_sel;

  axi_addr_decoder #(
    .S0_BASE     (S0_BASE),
    .S1_BASE     (S1_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_addr_decoder (
    .addr (M1_AWADDR),
    .sel  (sel_dec)
  );

  assign w_hs        = M1_WValid & M1_WReady;
  assign b_hs        = M1_BValid & M1_BReady;
  assign tgt_awready = |(sel_q & {DS_AWReady, S1_AWReady, S0_AWReady});
  assign tgt_wready  = |(sel_q & {DS_WReady, S1_WReady, S0_WReady});
  assign cnt_last    = (cnt_q == {1'b0, awlen_q});

`ifdef WRITE_BEAT_CHECK_EN
  assign beat_last = cnt_last;
`else
  assign beat_last = M1_WLast;
`endif

  always_comb begin
    state_d    = state_q;
    M1_AWReady = 1'b0;
    M1_WReady  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Gated by rst so AWReady is low while reset is held.
        M1_AWReady = rst;
        if (M1_AWValid) state_d = ST_AW_SEND;
      end
      ST_AW_SEND: begin
        if (tgt_awready) state_d = ST_W_FWD;
      end
      ST_W_FWD: begin
        M1_WReady = tgt_wready;
        if (M1_WValid && tgt_wready && beat_last) state_d = ST_B_WAIT;
      end
      ST_B_WAIT: begin
        if (b_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      awid_q    <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && M1_AWValid) begin
        awaddr_q  <= M1_AWADDR;
        awlen_q   <= M1_AWLEN;
        awsize_q  <= M1_AWSIZE;
        awburst_q <= M1_AWBURST;
        awid_q    <= {M1_TAG, M1_AWID};
        sel_q     <= sel_dec;
      end
      if (state_q == ST_AW_SEND && tgt_awready) cnt_q <= '0;
      else if (w_hs)                            cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef WRITE_BEAT_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 wlast_err <= 1'b0;
    else if (w_hs && (M1_WLast != cnt_last))  wlast_err <= 1'b1;
  end
`else
  // Master WLast must line up with the latched AWLEN.
  a_wlast_matches_len: assert property (@(posedge clk) disable iff (!rst)
    (w_hs && M1_WLast) |-> cnt_last);
`endif

  assign wr_busy = (state_q != ST_IDLE);
  assign aw_sel  = (state_q == ST_AW_SEND) ? sel_q : 3'b000;
  assign w_sel   = (state_q == ST_W_FWD)   ? sel_q : 3'b000;

  // Non-selected slaves see zeroed fields and deasserted valids.
  assign S0_AWValid = aw_sel[0];
  assign S0_AWID    = aw_sel[0] ? awid_q    : '0;
  assign S0_AWADDR  = aw_sel[0] ? awaddr_q  : '0;
  assign S0_AWLEN   = aw_sel[0] ? awlen_q   : '0;
  assign S0_AWSIZE  = aw_sel[0] ? awsize_q  : '0;
  assign S0_AWBURST = aw_sel[0] ? awburst_q : '0;
  assign S0_WValid  = w_sel[0] & M1_WValid;
  assign S0_WData   = w_sel[0] ? M1_WData : '0;
  assign S0_WStrb   = w_sel[0] ? M1_WStrb : '0;
  assign S0_WLast   = w_sel[0] & beat_last;

  assign S1_AWValid = aw_sel[1];
  assign S1_AWID    = aw_sel[1] ? awid_q    : '0;
  assign S1_AWADDR  = aw_sel[1] ? awaddr_q  : '0;
  assign S1_AWLEN   = aw_sel[1] ? awlen_q   : '0;
  assign S1_AWSIZE  = aw_sel[1] ? awsize_q  : '0;
  assign S1_AWBURST = aw_sel[1] ? awburst_q : '0;
  assign S1_WValid  = w_sel[1] & M1_WValid;
  assign S1_WData   = w_sel[1] ? M1_WData : '0;
  assign S1_WStrb   = w_sel[1] ? M1_WStrb : '0;
  assign S1_WLast   = w_sel[1] & beat_last;

  assign DS_AWValid = aw_sel[2];
  assign DS_AWID    = aw_sel[2] ? awid_q    : '0;
  assign DS_AWADDR  = aw_sel[2] ? awaddr_q  : '0;
  assign DS_AWLEN   = aw_sel[2] ? awlen_q   : '0;
  assign DS_AWSIZE  = aw_sel[2] ? awsize_q  : '0;
  assign DS_AWBURST = aw_sel[2] ? awburst_q : '0;
  assign DS_WValid  = w_sel[2] & M1_WValid;
  assign DS_WData   = w_sel[2] ? M1_WData : '0;
  assign DS_WStrb   = w_sel[2] ? M1_WStrb : '0;
  assign DS_WLast   = w_sel[2] & beat_last;

endmodule

// File: tb/tb_axi_write_router.sv
// Bench for axi_write_router: table of writes driven through a scoreboard of AW and W beats,
// plus sequences for AW held in B_WAIT, early WLast (option build) and reset mid-burst.
module tb_axi_write_router;

  logic clk, rst;
  logic [`AXI_ID_BITS-1:0]   M1_AWID;
  logic [`AXI_ADDR_BITS-1:0] M1_AWADDR;
  logic [`AXI_LEN_BITS-1:0]  M1_AWLEN;
  logic [`AXI_SIZE_BITS-1:0] M1_AWSIZE;
  logic [1:0]                M1_AWBURST;
  logic                      M1_AWValid, M1_AWReady;
  logic [`AXI_DATA_BITS-1:0] M1_WData;
  logic [`AXI_STRB_BITS-1:0] M1_WStrb;
  logic                      M1_WLast, M1_WValid, M1_WReady, M1_BValid, M1_BReady;
  logic [`AXI_IDS_BITS-1:0]  S0_AWID, S1_AWID, DS_AWID;
  logic [`AXI_ADDR_BITS-1:0] S0_AWADDR, S1_AWADDR, DS_AWADDR;
  logic [`AXI_LEN_BITS-1:0]  S0_AWLEN, S1_AWLEN, DS_AWLEN;
  logic [`AXI_SIZE_BITS-1:0] S0_AWSIZE, S1_AWSIZE, DS_AWSIZE;
  logic [1:0]                S0_AWBURST, S1_AWBURST, DS_AWBURST;
  logic                      S0_AWValid, S1_AWValid, DS_AWValid;
  logic                      S0_AWReady, S1_AWReady, DS_AWReady;
  logic [`AXI_DATA_BITS-1:0] S0_WData, S1_WData, DS_WData;
  logic [`AXI_STRB_BITS-1:0] S0_WStrb, S1_WStrb, DS_WStrb;
  logic                      S0_WLast, S1_WLast, DS_WLast;
  logic                      S0_WValid, S1_WValid, DS_WValid;
  logic                      S0_WReady, S1_WReady, DS_WReady;
  logic                      wr_busy;
`ifdef WRITE_BEAT_CHECK_EN
  logic                      wlast_err;
`endif

  axi_write_router dut (
    .clk(clk), .rst(rst),
    .M1_AWID(M1_AWID), .M1_AWADDR(M1_AWADDR), .M1_AWLEN(M1_AWLEN), .M1_AWSIZE(M1_AWSIZE),
    .M1_AWBURST(M1_AWBURST), .M1_AWValid(M1_AWValid), .M1_AWReady(M1_AWReady),
    .M1_WData(M1_WData), .M1_WStrb(M1_WStrb), .M1_WLast(M1_WLast), .M1_WValid(M1_WValid),
    .M1_WReady(M1_WReady), .M1_BValid(M1_BValid), .M1_BReady(M1_BReady),
    .S0_AWID(S0_AWID), .S0_AWADDR(S0_AWADDR), .S0_AWLEN(S0_AWLEN), .S0_AWSIZE(S0_AWSIZE),
    .S0_AWBURST(S0_AWBURST), .S0_AWValid(S0_AWValid), .S0_AWReady(S0_AWReady),
    .S0_WData(S0_WData), .S0_WStrb(S0_WStrb), .S0_WLast(S0_WLast), .S0_WValid(S0_WValid),
    .S0_WReady(S0_WReady),
    .S1_AWID(S1_AWID), .S1_AWADDR(S1_AWADDR), .S1_AWLEN(S1_AWLEN), .S1_AWSIZE(S1_AWSIZE),
    .S1_AWBURST(S1_AWBURST), .S1_AWValid(S1_AWValid), .S1_AWReady(S1_AWReady),
    .S1_WData(S1_WData), .S1_WStrb(S1_WStrb), .S1_WLast(S1_WLast), .S1_WValid(S1_WValid),
    .S1_WReady(S1_WReady),
    .DS_AWID(DS_AWID), .DS_AWADDR(DS_AWADDR), .DS_AWLEN(DS_AWLEN), .DS_AWSIZE(DS_AWSIZE),
    .DS_AWBURST(DS_AWBURST), .DS_AWValid(DS_AWValid), .DS_AWReady(DS_AWReady),
    .DS_WData(DS_WData), .DS_WStrb(DS_WStrb), .DS_WLast(DS_WLast), .DS_WValid(DS_WValid),
    .DS_WReady(DS_WReady),
    .wr_busy(wr_busy)
`ifdef WRITE_BEAT_CHECK_EN
    , .wlast_err(wlast_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  id;
    logic [2:0]  sel;
    logic [7:0]  exp_id;
    bit          toggle;
    int          early;
  } vec_t;

  localparam int BUDGET = 300;

  int checks = 0;
  int errors = 0;
  // AW expectation: {sel, id, addr, len, size, burst}; W expectation: {sel, data, strb, last}.
  logic [51:0] aw_q[$];
  logic [39:0] w_q[$];
  logic        aw_hs_s, w_hs_s, busy_s, awrdy_s, wrdy_s;
  logic [2:0]  awv_s;
  bit          awv_expect = 0;
  logic [2:0]  awv_sel;
  logic [31:0] cur_addr;
  logic [3:0]  cur_len;
  int          cur_bad;
  logic [31:0] nxt_addr;
  logic [3:0]  nxt_len, nxt_id;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wdat(input logic [31:0] a, input int b);
    logic [31:0] k;
    k = 32'(b + 1);
    return a ^ (k * 32'h0101_0111);
  endfunction

  // Observe outputs at the falling edge; handshakes complete at the next rising edge.
  task automatic monitor();
    logic [2:0]  awv, awr, wv, wr;
    logic [51:0] aw_obs[3];
    logic [39:0] w_obs[3];
    awv = {DS_AWValid, S1_AWValid, S0_AWValid};
    awr = {DS_AWReady, S1_AWReady, S0_AWReady};
    wv  = {DS_WValid, S1_WValid, S0_WValid};
    wr  = {DS_WReady, S1_WReady, S0_WReady};
    aw_obs[0] = {3'b001, S0_AWID, S0_AWADDR, S0_AWLEN, S0_AWSIZE, S0_AWBURST};
    aw_obs[1] = {3'b010, S1_AWID, S1_AWADDR, S1_AWLEN, S1_AWSIZE, S1_AWBURST};
    aw_obs[2] = {3'b100, DS_AWID, DS_AWADDR, DS_AWLEN, DS_AWSIZE, DS_AWBURST};
    w_obs[0]  = {3'b001, S0_WData, S0_WStrb, S0_WLast};
    w_obs[1]  = {3'b010, S1_WData, S1_WStrb, S1_WLast};
    w_obs[2]  = {3'b100, DS_WData, DS_WStrb, DS_WLast};
    aw_hs_s = M1_AWValid & M1_AWReady;
    w_hs_s  = M1_WValid & M1_WReady;
    busy_s  = wr_busy;
    awrdy_s = M1_AWReady;
    wrdy_s  = M1_WReady;
    awv_s   = awv;
    check_eq("valid_onehot", {63'd0, ($countones(awv) <= 1) && ($countones(wv) <= 1)}, 64'd1);
    if (awv_expect) begin
      check_eq("aw_latency", {61'd0, awv}, {61'd0, awv_sel});
      awv_expect = 0;
    end
    for (int s = 0; s < 3; s++) begin
      if (awv[s] && awr[s]) begin
        if (aw_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_unexpected act=%0h exp=none", aw_obs[s]);
        end else check_eq("aw_fields", {12'd0, aw_obs[s]}, {12'd0, aw_q.pop_front()});
      end
      if (wv[s] && wr[s]) begin
        if (w_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected act=%0h exp=none", w_obs[s]);
        end else check_eq("w_beat", {24'd0, w_obs[s]}, {24'd0, w_q.pop_front()});
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int b);
    M1_WData = wdat(cur_addr, b);
    M1_WStrb = 4'hF ^ 4'(b);
    M1_WLast = (b == int'(cur_len)) || (b == cur_bad);
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] sel, input logic [7:0] exp_id);
    aw_q.push_back({sel, exp_id, addr, len, 3'd2, 2'b01});
    for (int b = 0; b <= int'(len); b++)
      w_q.push_back({sel, wdat(addr, b), 4'hF ^ 4'(b), 1'b0 | (b == int'(len))});
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input logic [2:0] sel, input logic [7:0] exp_id, input bit toggle,
                          input int early, input int bad_last, input bit hold, input bit aw_pre);
    int  beat, cyc;
    bit  aw_done;
    cur_addr = addr; cur_len = len; cur_bad = bad_last;
    push_exp(addr, len, sel, exp_id);
    S0_WReady = 1'b1; S1_WReady = 1'b1; DS_WReady = 1'b1;
    awv_sel = sel;
    M1_AWID = id; M1_AWADDR = addr; M1_AWLEN = len; M1_AWSIZE = 3'd2; M1_AWBURST = 2'b01;
    M1_WValid = 1'b1;
    drive_beat(0);
    aw_done = aw_pre;
    if (aw_pre) awv_expect = 1;
    for (int e = 0; e < early; e++) begin
      step();
      check_eq("w_stall_pre_aw", {63'd0, wrdy_s}, 64'd0);
    end
    M1_AWValid = !aw_pre;
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < BUDGET) begin
      if (toggle) begin
        S0_WReady = cyc[0]; S1_WReady = cyc[0]; DS_WReady = cyc[0];
      end
      step();
      if (w_hs_s && !aw_done) begin
        checks++; errors++;
        $display("FAIL w_before_aw act=1 exp=0");
      end
      if (aw_hs_s) begin
        M1_AWValid = 1'b0; aw_done = 1; awv_expect = 1;
      end
      if (w_hs_s) begin
        beat++;
        if (beat <= int'(len)) drive_beat(beat);
        else M1_WValid = 1'b0;
      end
      cyc++;
    end
    check_eq("w_timeout", {63'd0, cyc < BUDGET}, 64'd1);
    M1_WValid = 1'b0;
    if (hold) begin
      M1_AWValid = 1'b1; M1_AWADDR = nxt_addr; M1_AWLEN = nxt_len; M1_AWID = nxt_id;
    end
    M1_BValid = 1'b1; M1_BReady = 1'b1;
    step();
    check_eq("busy_in_b_wait", {63'd0, busy_s}, 64'd1);
    check_eq("awrdy_in_b_wait", {63'd0, awrdy_s}, 64'd0);
    M1_BValid = 1'b0; M1_BReady = 1'b0;
    step();
    check_eq("busy_after_b", {63'd0, busy_s}, 64'd0);
    check_eq("awrdy_idle", {63'd0, awrdy_s}, 64'd1);
    if (hold) begin
      check_eq("aw_held_accepted", {63'd0, aw_hs_s}, 64'd1);
      M1_AWValid = 1'b0;
    end
  endtask

  vec_t vecs[7];

  initial begin
    int beat, cyc;
    vecs[0] = '{32'h0000_0040, 4'd0,  4'h3, 3'b001, 8'h13, 1'b0, 0};
    vecs[1] = '{32'h0001_0000, 4'd3,  4'h5, 3'b010, 8'h15, 1'b1, 0};
    vecs[2] = '{32'h0003_0000, 4'd1,  4'hA, 3'b100, 8'h1A, 1'b0, 0};
    vecs[3] = '{32'h0000_1234, 4'd2,  4'h7, 3'b001, 8'h17, 1'b0, 2};
    vecs[4] = '{32'h0001_FFFC, 4'd15, 4'hF, 3'b010, 8'h1F, 1'b0, 0};
    vecs[5] = '{32'h0002_0000, 4'd0,  4'h0, 3'b100, 8'h10, 1'b0, 0};
    vecs[6] = '{32'hFFFF_0000, 4'd4,  4'h9, 3'b100, 8'h19, 1'b1, 0};

    rst = 1'b0;
    M1_AWID = '0; M1_AWADDR = '0; M1_AWLEN = '0; M1_AWSIZE = '0; M1_AWBURST = '0;
    M1_AWValid = 1'b0; M1_WData = '0; M1_WStrb = '0; M1_WLast = 1'b0; M1_WValid = 1'b0;
    M1_BValid = 1'b0; M1_BReady = 1'b0;
    S0_AWReady = 1'b1; S1_AWReady = 1'b1; DS_AWReady = 1'b1;
    S0_WReady = 1'b1; S1_WReady = 1'b1; DS_WReady = 1'b1;
    #1;
    step();
    check_eq("rst_awready", {63'd0, awrdy_s}, 64'd0);
    check_eq("rst_wready", {63'd0, wrdy_s}, 64'd0);
    check_eq("rst_busy", {63'd0, busy_s}, 64'd0);
    check_eq("rst_awvalid", {61'd0, awv_s}, 64'd0);
`ifdef WRITE_BEAT_CHECK_EN
    check_eq("rst_wlast_err", {63'd0, wlast_err}, 64'd0);
`endif
    rst = 1'b1;
    step();
    check_eq("idle_awready", {63'd0, awrdy_s}, 64'd1);

    for (int i = 0; i < 7; i++)
      do_write(vecs[i].addr, vecs[i].len, vecs[i].id, vecs[i].sel, vecs[i].exp_id,
               vecs[i].toggle, vecs[i].early, -1, 1'b0, 1'b0);

    // Second AW held through B_WAIT, accepted the cycle after the B handshake.
    nxt_addr = 32'h0001_0100; nxt_len = 4'd1; nxt_id = 4'h2;
    do_write(32'h0000_0080, 4'd1, 4'h4, 3'b001, 8'h14, 1'b0, 0, -1, 1'b1, 1'b0);
    do_write(32'h0001_0100, 4'd1, 4'h2, 3'b010, 8'h12, 1'b0, 0, -1, 1'b0, 1'b1);

`ifdef WRITE_BEAT_CHECK_EN
    // Early WLast on the second beat of a 4-beat burst: slave still sees 4 beats.
    check_eq("wlast_err_before", {63'd0, wlast_err}, 64'd0);
    do_write(32'h0000_0300, 4'd3, 4'h6, 3'b001, 8'h16, 1'b0, 0, 1, 1'b0, 1'b0);
    check_eq("wlast_err_after", {63'd0, wlast_err}, 64'd1);
`endif

    // Reset asserted at beat 2 of an 8-beat burst.
    cur_addr = 32'h0000_0200; cur_len = 4'd7; cur_bad = -1;
    push_exp(32'h0000_0200, 4'd7, 3'b001, 8'h14);
    awv_sel = 3'b001;
    M1_AWID = 4'h4; M1_AWADDR = 32'h0000_0200; M1_AWLEN = 4'd7; M1_AWSIZE = 3'd2;
    M1_AWBURST = 2'b01; M1_AWValid = 1'b1; M1_WValid = 1'b1;
    drive_beat(0);
    beat = 0; cyc = 0;
    while (beat < 2 && cyc < BUDGET) begin
      step();
      if (aw_hs_s) begin M1_AWValid = 1'b0; awv_expect = 1; end
      if (w_hs_s) begin beat++; drive_beat(beat); end
      cyc++;
    end
    check_eq("rst_burst_timeout", {63'd0, cyc < BUDGET}, 64'd1);
    check_eq("pre_rst_s0_wvalid", {63'd0, S0_WValid}, 64'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_wvalid", {61'd0, DS_WValid, S1_WValid, S0_WValid}, 64'd0);
    check_eq("async_rst_awvalid", {61'd0, DS_AWValid, S1_AWValid, S0_AWValid}, 64'd0);
    check_eq("async_rst_wready", {63'd0, M1_WReady}, 64'd0);
    check_eq("async_rst_busy", {63'd0, wr_busy}, 64'd0);
`ifdef WRITE_BEAT_CHECK_EN
    check_eq("async_rst_wlast_err", {63'd0, wlast_err}, 64'd0);
`endif
    M1_WValid = 1'b0; M1_WLast = 1'b0;
    aw_q.delete(); w_q.delete(); awv_expect = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    check_eq("post_rst_awready", {63'd0, awrdy_s}, 64'd1);
    check_eq("post_rst_busy", {63'd0, busy_s}, 64'd0);

    // A clean write after the abort still routes correctly.
    do_write(32'h0000_0010, 4'd1, 4'h8, 3'b001, 8'h18, 1'b0, 0, -1, 1'b0, 1'b0);

    check_eq("aw_q_drained", 64'(aw_q.size()), 64'd0);
    check_eq("w_q_drained", 64'(w_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
